// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, write ports and the busy-bit scoreboard controls.
// The master side is decode/issue plus writeback; the slave side is the register file.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     sb_set;
  logic [ADDR_W-1:0]        sb_set_addr;
  logic                     sb_flush;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_set_addr, sb_flush,
    input  rd_data, rd_busy
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_set_addr, sb_flush,
    output rd_data, rd_busy
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with registered reads and a busy-bit scoreboard (r0 hardwired to 0).
// Optional macro RF_BYPASS_EN: same-cycle write-to-read forwarding (write-first); default is read-first.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic        clk,
  input  logic        rst,
  regfile_mp_if.slave bus
);
  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};

  logic [DATA_W-1:0]        r_regs [NREG];
  logic [NREG-1:0]          r_busy;
  logic [NREG-1:0]          w_busy_nxt;
  logic [NUM_RD*DATA_W-1:0] r_rd_data;
  logic [NUM_RD*DATA_W-1:0] w_rd_val;
  logic [NUM_RD-1:0]        r_rd_busy;
  logic [NUM_RD-1:0]        w_rd_busy;

  // Register array; later write ports overwrite earlier ones on an address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (bus.wr_en[w] && (bus.wr_addr[w*ADDR_W +: ADDR_W] != ZERO_A)) begin
          r_regs[bus.wr_addr[w*ADDR_W +: ADDR_W]] <= bus.wr_data[w*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Scoreboard next state: flush, else write-clear followed by set so a new producer wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (bus.sb_flush) begin
      w_busy_nxt = {NREG{1'b0}};
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        w_busy_nxt[bus.wr_addr[w*ADDR_W +: ADDR_W]] =
          w_busy_nxt[bus.wr_addr[w*ADDR_W +: ADDR_W]] & ~bus.wr_en[w];
      end
      w_busy_nxt[bus.sb_set_addr] = w_busy_nxt[bus.sb_set_addr] | bus.sb_set;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Read value selection; busy is sampled after this cycle's scoreboard update.
  always_comb begin
    w_rd_val  = {(NUM_RD*DATA_W){1'b0}};
    w_rd_busy = {NUM_RD{1'b0}};
    for (int p = 0; p < NUM_RD; p++) begin
      w_rd_val[p*DATA_W +: DATA_W] = r_regs[bus.rd_addr[p*ADDR_W +: ADDR_W]];
`ifdef RF_BYPASS_EN
      for (int w = 0; w < NUM_WR; w++) begin
        w_rd_val[p*DATA_W +: DATA_W] =
          (bus.wr_en[w] && (bus.wr_addr[w*ADDR_W +: ADDR_W] != ZERO_A) &&
           (bus.wr_addr[w*ADDR_W +: ADDR_W] == bus.rd_addr[p*ADDR_W +: ADDR_W]))
          ? bus.wr_data[w*DATA_W +: DATA_W] : w_rd_val[p*DATA_W +: DATA_W];
      end
`endif
      w_rd_busy[p] = w_busy_nxt[bus.rd_addr[p*ADDR_W +: ADDR_W]];
    end
  end

  // Busy bits and enable-gated read output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy    <= {NREG{1'b0}};
      r_rd_data <= {(NUM_RD*DATA_W){1'b0}};
      r_rd_busy <= {NUM_RD{1'b0}};
    end else begin
      r_busy <= w_busy_nxt;
      for (int p = 0; p < NUM_RD; p++) begin
        if (bus.rd_en[p]) begin
          r_rd_data[p*DATA_W +: DATA_W] <= w_rd_val[p*DATA_W +: DATA_W];
          r_rd_busy[p]                  <= w_rd_busy[p];
        end
      end
    end
  end

  assign bus.rd_data = r_rd_data;
  assign bus.rd_busy = r_rd_busy;
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vector table, random traffic against a
// rule-level reference model, mid-cycle reset, and a 4-read/1-write instance.
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;
  localparam int NW = 2;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) u_if ();
  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(4),  .NUM_WR(1))  u_if1 ();

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) u_dut (
    .clk(clk), .rst(rst), .bus(u_if.slave));
  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(4), .NUM_WR(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(u_if1.slave));

  typedef struct {
    logic [NR-1:0]    rd_en;
    logic [NR*AW-1:0] rd_addr;
    logic [NW-1:0]    wr_en;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*DW-1:0] wr_data;
    logic             sb_set;
    logic [AW-1:0]    sb_addr;
    logic             sb_flush;
    logic [NR-1:0]    mask;
    logic [NR*DW-1:0] exp_data;
    logic [NR-1:0]    exp_busy;
  } vec_t;

  vec_t tbl [18];

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [DW-1:0] m_regs [32];
  bit            m_busy [32];
  logic [DW-1:0] m_exp_data [NR];
  bit            m_exp_busy [NR];

  function automatic vec_t mk(
    input logic [3:0] re, input logic [4:0] a0, a1, a2, a3,
    input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
    input logic [4:0] wa1, input logic [31:0] wd1,
    input logic ss, input logic [4:0] sa, input logic fl,
    input logic [3:0] mask, input logic [31:0] e0, e1, e2, e3, input logic [3:0] eb);
    vec_t v;
    v.rd_en = re; v.rd_addr = {a3, a2, a1, a0};
    v.wr_en = we; v.wr_addr = {wa1, wa0}; v.wr_data = {wd1, wd0};
    v.sb_set = ss; v.sb_addr = sa; v.sb_flush = fl;
    v.mask = mask; v.exp_data = {e3, e2, e1, e0}; v.exp_busy = eb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit busy_after(input int a);
    if (a == 0) return 1'b0;
    if (u_if.sb_flush) return 1'b0;
    if (u_if.sb_set && int'(u_if.sb_set_addr) == a) return 1'b1;
    for (int w = 0; w < NW; w++)
      if (u_if.wr_en[w] && int'(u_if.wr_addr[w*AW +: AW]) == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [DW-1:0] read_val(input int a);
    logic [DW-1:0] v;
    v = m_regs[a];
    if (BYP)
      for (int w = 0; w < NW; w++)
        if (u_if.wr_en[w] && u_if.wr_addr[w*AW +: AW] != 5'd0 && int'(u_if.wr_addr[w*AW +: AW]) == a)
          v = u_if.wr_data[w*DW +: DW];
    return v;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < 32; a++) begin m_regs[a] = 32'd0; m_busy[a] = 1'b0; end
    for (int p = 0; p < NR; p++) begin m_exp_data[p] = 32'd0; m_exp_busy[p] = 1'b0; end
  endtask

  // One clock: predict from current inputs, advance the model, then compare after the edge.
  task automatic cycle();
    bit nb [32];
    for (int p = 0; p < NR; p++) begin
      if (u_if.rd_en[p]) begin
        m_exp_data[p] = read_val(int'(u_if.rd_addr[p*AW +: AW]));
        m_exp_busy[p] = busy_after(int'(u_if.rd_addr[p*AW +: AW]));
      end
    end
    for (int a = 0; a < 32; a++) nb[a] = busy_after(a);
    for (int w = 0; w < NW; w++)
      if (u_if.wr_en[w] && u_if.wr_addr[w*AW +: AW] != 5'd0)
        m_regs[u_if.wr_addr[w*AW +: AW]] = u_if.wr_data[w*DW +: DW];
    for (int a = 0; a < 32; a++) m_busy[a] = nb[a];
    @(posedge clk);
    #1;
    for (int p = 0; p < NR; p++) begin
      check($sformatf("model rd_data[%0d]", p), u_if.rd_data[p*DW +: DW], m_exp_data[p]);
      check($sformatf("model rd_busy[%0d]", p), {31'd0, u_if.rd_busy[p]}, {31'd0, m_exp_busy[p]});
    end
  endtask

  task automatic drive(input vec_t v);
    u_if.rd_en = v.rd_en; u_if.rd_addr = v.rd_addr;
    u_if.wr_en = v.wr_en; u_if.wr_addr = v.wr_addr; u_if.wr_data = v.wr_data;
    u_if.sb_set = v.sb_set; u_if.sb_set_addr = v.sb_addr; u_if.sb_flush = v.sb_flush;
  endtask

  initial begin
    vec_t idle;
    idle = mk(4'b0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0,
              1'b0, 5'd0, 1'b0, 4'b0, 32'd0, 32'd0, 32'd0, 32'd0, 4'b0);
    // re a0 a1 a2 a3 | we wa0 wd0 wa1 wd1 | ss sa fl | mask e0 e1 e2 e3 eb
    tbl[0]  = mk(4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 2'b01, 5'd5, 32'h40, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000);
    tbl[1]  = mk(4'b0010, 5'd0, 5'd5, 5'd0, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 4'b0010, 32'h0, 32'h40, 32'h0, 32'h0, 4'b0000);
    tbl[2]  = mk(4'b0000, 5'd0, 5'd7, 5'd0, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 4'b0010, 32'h0, 32'h40, 32'h0, 32'h0, 4'b0000);
    tbl[3]  = mk(4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000);
    tbl[4]  = mk(4'b0100, 5'd0, 5'd0, 5'd7, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 4'b0100, 32'h0, 32'h0, 32'h22, 32'h0, 4'b0000);
    tbl[5]  = mk(4'b0001, 5'd3, 5'd0, 5'd0, 5'd0, 2'b01, 5'd3, 32'h99, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 4'b0001, BYP ? 32'h99 : 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000);
    tbl[6]  = mk(4'b0001, 5'd3, 5'd0, 5'd0, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 4'b0001, 32'h99, 32'h0, 32'h0, 32'h0, 4'b0000);
    tbl[7]  = mk(4'b1000, 5'd0, 5'd0, 5'd0, 5'd9, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 4'b1000, 32'h0, 32'h0, 32'h0, 32'h0, 4'b1000);
    tbl[8]  = mk(4'b1000, 5'd0, 5'd0, 5'd0, 5'd9, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 4'b1000, 32'h0, 32'h0, 32'h0, 32'h0, 4'b1000);
    tbl[9]  = mk(4'b1000, 5'd0, 5'd0, 5'd0, 5'd9, 2'b10, 5'd0, 32'h0, 5'd9, 32'h5, 1'b1, 5'd9, 1'b0, 4'b1000, 32'h0, 32'h0, 32'h0, BYP ? 32'h5 : 32'h0, 4'b1000);
    tbl[10] = mk(4'b1000, 5'd0, 5'd0, 5'd0, 5'd9, 2'b01, 5'd9, 32'h6, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 4'b1000, 32'h0, 32'h0, 32'h0, BYP ? 32'h6 : 32'h5, 4'b0000);
    tbl[11] = mk(4'b0100, 5'd0, 5'd0, 5'd4, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1, 4'b0100, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000);
    tbl[12] = mk(4'b0100, 5'd0, 5'd0, 5'd4, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 4'b0100, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000);
    tbl[13] = mk(4'b0001, 5'd0, 5'd0, 5'd0, 5'd0, 2'b01, 5'd0, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 4'b0001, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000);
    tbl[14] = mk(4'b0011, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 4'b0011, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000);
    tbl[15] = mk(4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 2'b11, 5'd1, 32'h1, 5'd2, 32'h2, 1'b0, 5'd0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000);
    tbl[16] = mk(4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 2'b11, 5'd3, 32'h3, 5'd4, 32'h4, 1'b0, 5'd0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000);
    tbl[17] = mk(4'b1111, 5'd1, 5'd2, 5'd3, 5'd4, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 4'b1111, 32'h1, 32'h2, 32'h3, 32'h4, 4'b0000);

    drive(idle);
    u_if1.rd_en = 4'b0; u_if1.rd_addr = 20'd0; u_if1.wr_en = 1'b0; u_if1.wr_addr = 5'd0;
    u_if1.wr_data = 32'd0; u_if1.sb_set = 1'b0; u_if1.sb_set_addr = 5'd0; u_if1.sb_flush = 1'b0;
    model_reset();

    #2;
    check("reset rd_data", u_if.rd_data[31:0] | u_if.rd_data[127:96], 32'd0);
    check("reset rd_busy", {28'd0, u_if.rd_busy}, 32'd0);
    repeat (2) @(posedge clk);
    #4 rst = 1'b0;

    // directed table
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i]);
      cycle();
      for (int p = 0; p < NR; p++) begin
        if (tbl[i].mask[p]) begin
          check($sformatf("vec%0d rd_data[%0d]", i, p), u_if.rd_data[p*DW +: DW], tbl[i].exp_data[p*DW +: DW]);
          check($sformatf("vec%0d rd_busy[%0d]", i, p), {31'd0, u_if.rd_busy[p]}, {31'd0, tbl[i].exp_busy[p]});
        end
      end
    end

    // random traffic, addresses concentrated to provoke hazards
    for (int i = 0; i < 400; i++) begin
      u_if.rd_en = 4'($urandom);
      for (int p = 0; p < NR; p++) u_if.rd_addr[p*AW +: AW] = 5'($urandom_range(0, 7));
      u_if.wr_en = 2'($urandom);
      for (int w = 0; w < NW; w++) begin
        u_if.wr_addr[w*AW +: AW] = 5'($urandom_range(0, 7));
        u_if.wr_data[w*DW +: DW] = $urandom;
      end
      u_if.sb_set = 1'($urandom);
      u_if.sb_set_addr = 5'($urandom_range(0, 7));
      u_if.sb_flush = ($urandom_range(0, 15) == 0);
      cycle();
    end

    // mid-cycle reset with nonzero read data
    drive(mk(4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 2'b01, 5'd12, 32'h12345678, 5'd0, 32'h0, 1'b1, 5'd12, 1'b0, 4'b0, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0));
    cycle();
    drive(mk(4'b0001, 5'd12, 5'd0, 5'd0, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 4'b0, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0));
    cycle();
    check("pre-reset rd_data[0]", u_if.rd_data[31:0], 32'h12345678);
    drive(idle);
    #3 rst = 1'b1;
    #1;
    for (int p = 0; p < NR; p++) begin
      check($sformatf("async reset rd_data[%0d]", p), u_if.rd_data[p*DW +: DW], 32'd0);
      check($sformatf("async reset rd_busy[%0d]", p), {31'd0, u_if.rd_busy[p]}, 32'd0);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(mk(4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 2'b10, 5'd0, 32'h0, 5'd10, 32'hCAFE, 1'b0, 5'd0, 1'b0, 4'b0, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0));
    cycle();
    drive(mk(4'b0101, 5'd12, 5'd0, 5'd10, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 4'b0, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0));
    cycle();
    check("post-reset r10", u_if.rd_data[2*DW +: DW], 32'hCAFE);
    check("post-reset r12 cleared", u_if.rd_data[31:0], 32'd0);
    drive(idle);

    // 4-read / 1-write instance: preload r1..r4 then read all ports at once
    for (int i = 1; i <= 4; i++) begin
      u_if1.wr_en = 1'b1; u_if1.wr_addr = 5'(i); u_if1.wr_data = 32'(i);
      @(posedge clk); #1;
    end
    u_if1.wr_en = 1'b0;
    u_if1.rd_en = 4'hF;
    u_if1.rd_addr = {5'd4, 5'd3, 5'd2, 5'd1};
    @(posedge clk); #1;
    for (int p = 0; p < 4; p++)
      check($sformatf("nr4nw1 rd_data[%0d]", p), u_if1.rd_data[p*DW +: DW], 32'(p + 1));
    check("nr4nw1 rd_busy", {28'd0, u_if1.rd_busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file, the successor to the two-read/one-write core register file. It supports a configurable number of read and write ports and registered, enable-gated reads. A busy-bit scoreboard lets issue logic detect pending writes, such as outstanding loads, without a separate hazard table. It sits between decode/issue (read and scoreboard-set side) and writeback (write and scoreboard-clear side).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width; the file holds 2**ADDR_W entries
NUM_RD, 2, number of read ports (1..4)
NUM_WR, 2, number of write ports (1..2)

Ports:
clk  input  1  single clock; all state updates on posedge
rst  input  1  asynchronous, active-high reset
rd_en  input  NUM_RD  per-port read enable
rd_addr  input  NUM_RD*ADDR_W  read addresses; port p occupies bits [p*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  registered read data, packed the same way
rd_busy  output  NUM_RD  registered busy bit of the addressed register
wr_en  input  NUM_WR  per-port write enable
wr_addr  input  NUM_WR*ADDR_W  write addresses
wr_data  input  NUM_WR*DATA_W  write data
sb_set  input  1  mark sb_set_addr busy (destination issued)
sb_set_addr  input  ADDR_W  register to mark busy
sb_flush  input  1  clear every busy bit (pipeline flush)

Behaviour:
- Reset is asynchronous and active-high. While rst=1:
  - all registers are 0
  - rd_data=0 and rd_busy=0
  - all busy bits are 0
  - takes effect immediately, even mid-cycle. The first write is accepted on the first posedge after rst falls.
- Register 0 reads as 0 and is never busy.
  - A write to address 0 is dropped.
  - sb_set with address 0 is ignored.
- Writes: on posedge, for each port w with wr_en[w]=1 and a nonzero address, reg[wr_addr[w]] <= wr_data[w].
  - If both write ports target the same address, port NUM_WR-1 wins.
- Reads have 1-cycle latency. On posedge, for each port p with rd_en[p]=1, rd_data[p] and rd_busy[p] are loaded.
  - With rd_en[p]=0, both outputs hold their previous value.
  - The read value is taken from the register array, or from the bypass path when RF_BYPASS_EN is defined.
- Scoreboard: one busy bit per register, updated on posedge in this priority order:
  - 1. sb_flush=1 clears all bits. A same-cycle sb_set is ignored.
  - 2. Otherwise, any write with wr_en=1 clears busy[wr_addr].
  - 3. sb_set=1 sets busy[sb_set_addr]. Set beats a same-cycle clear of the same register, because the new producer wins.
- rd_busy reflects the busy-bit value after this cycle's update, using the same priority.
  - A register being cleared by a write this cycle reads not-busy.
  - A register being set this cycle reads busy.
- No combinational path exists from any input to any output. All outputs are registered.

Optional Feature:
RF_BYPASS_EN
- Defined: a read whose address matches an active, nonzero write in the same cycle returns that write's data, the highest-index matching write port taking priority. This is write-first behaviour.
- Undefined: a same-cycle read returns the old array contents (read-first). The new value becomes visible one cycle later.
- Scoreboard behaviour is identical in both builds.

Test Plan:
- Reset and zero register: assert rst mid-run with rd_data nonzero -> rd_data=0 and rd_busy=0 immediately. Then write 0xDEADBEEF to r0 and read r0 -> 0x00000000.
- Basic read/write: write r5=0x40 on port 0; next cycle read r5 on port 1 -> rd_data[1]=0x40 one cycle after rd_en. Drop rd_en -> value holds.
- Write collision: in the same cycle, port 0 writes r7=0x11 and port 1 writes r7=0x22 -> a later read of r7 returns 0x22.
- Bypass: write r3=0x99 and read r3 in the same cycle.
  - RF_BYPASS_EN defined -> rd_data=0x99.
  - RF_BYPASS_EN undefined -> old value 0x0; the next read returns 0x99.
- Scoreboard:
  - sb_set r9 -> a read of r9 shows rd_busy=1.
  - Write r9 while also issuing sb_set r9 -> busy stays 1.
  - Write r9 alone -> busy=0.
  - sb_set r4 with sb_flush=1 -> r4 not busy.
- Multi-port: NUM_RD=4, NUM_WR=1. Preload r1..r4 = 1,2,3,4, then read all four ports at once -> rd_data={4,3,2,1} (port 3 in the high bits).
